// File: rtl/muldiv_issue_ctrl.sv
// EX-stage issue controller for the multi-cycle M-extension ALU: holds operands/op stable,
// waits for ready, returns the tagged result, and separates ops with ALU_ADD.
module muldiv_issue_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned OP_W    = 4,
  parameter logic [OP_W-1:0] ALU_ADD = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic             alu_ready,
  input  logic [XLEN-1:0]  alu_result,
  output logic             rsp_valid,
  output logic [XLEN-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StIssue = 3'd1;
  localparam logic [2:0] StWait  = 3'd2;
  localparam logic [2:0] StResp  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic             expired;

  assign expired = ((state_q == StWait) || (state_q == StDrain)) && (cnt_q == CntW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    rtag_d      = rtag_q;
    timeout_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid && !flush) begin
          state_d = StIssue;
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          tag_d   = req_tag;
          cnt_d   = '0;
        end
      end
      // alu_ready may still reflect the previous op here, so it is not looked at.
      StIssue: state_d = flush ? StDrain : StWait;
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (expired) begin
          timeout_err = 1'b1;
          state_d     = StIdle;
          op_d        = ALU_ADD;
        end else if (alu_ready) begin
          op_d = ALU_ADD;
          if (flush) begin
            state_d = StIdle;
          end else begin
            state_d = StResp;
            res_d   = alu_result;
            rtag_d  = tag_q;
          end
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StResp: state_d = StIdle;
      // Keep the op stable so the divider finishes rather than restarting.
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (expired) begin
          timeout_err = 1'b1;
          state_d     = StIdle;
          op_d        = ALU_ADD;
        end else if (alu_ready) begin
          state_d = StIdle;
          op_d    = ALU_ADD;
        end
      end
      default: begin
        state_d = StIdle;
        op_d    = ALU_ADD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rtag_q  <= rtag_d;
    end
  end

  assign req_ready  = (state_q == StIdle) && !flush;
  assign busy       = (state_q != StIdle);
  assign rsp_valid  = (state_q == StResp) && !flush;
  assign rsp_result = res_q;
  assign rsp_tag    = rtag_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: ALU stub with programmable latency, directed scenarios and
// randomized transactions checked against a cycle-number based transaction model.
module tb_muldiv_issue_ctrl;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_MULH  = 4'd9;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REM   = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = OP_ADD;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_ready;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic        busy;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  muldiv_issue_ctrl #(.XLEN(32), .TAG_W(5), .TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .flush      (flush),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_ready  (alu_ready),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'b0, a} * {32'b0, b};
    case (op)
      OP_ADD:   return a + b;
      OP_MUL:   return up[31:0];
      OP_MULH:  return sp[63:32];
      OP_MULHU: return up[63:32];
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      OP_REMU:  return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  // ALU stub: ready appears stub_lat cycles after the op has been stable for one cycle.
  bit         stub_always = 1'b0;
  bit         stub_stuck = 1'b0;
  int         stub_lat = 0;
  logic [3:0] prev_op = OP_ADD;
  int         age = 0;

  always @(posedge clk) begin
    prev_op <= alu_op;
    if (alu_op != prev_op) age <= 0;
    else if (age < 1000) age <= age + 1;
  end

  always_comb begin
    alu_ready  = stub_stuck ? 1'b0 :
                 stub_always ? 1'b1 : ((alu_op == prev_op) && (age >= stub_lat));
    alu_result = golden(alu_op, alu_a, alu_b);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  logic [31:0] held_res = '0;
  logic [4:0]  held_tag = '0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after a rising edge with the controller idle.
  // Accept edge ends cycle 0; ready first sampled in cycle r=2+lat; flush pulses in cycle f.
  task automatic do_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int lat, input int f,
                        input logic [31:0] exp);
    int  r, busy_last;
    bit  capture, visible;
    stub_lat  = lat;
    r         = 2 + lat;
    capture   = !(f >= 1 && f <= r);
    visible   = capture && (f != r + 1);
    busy_last = capture ? r + 1 : r;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(negedge clk);
    check("accept_ready", 32'(req_ready), 32'd1);
    next_cycle();
    req_valid = 1'b0;
    req_op    = 4'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    req_tag   = 5'($urandom);
    for (int c = 1; c <= r + 2; c++) begin
      flush = (c == f);
      @(negedge clk);
      check("busy", 32'(busy), 32'(c <= busy_last));
      check("rsp_valid", 32'(rsp_valid), 32'(visible && c == r + 1));
      check("req_ready", 32'(req_ready), 32'(c > busy_last && c != f));
      check("alu_op", 32'(alu_op), 32'((c <= r) ? op : OP_ADD));
      check("timeout_err", 32'(timeout_err), 32'd0);
      if (c <= r) begin
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
      end
      check("rsp_result", rsp_result, (capture && c >= r + 1) ? exp : held_res);
      check("rsp_tag", 32'(rsp_tag), 32'((capture && c >= r + 1) ? tag : held_tag));
      next_cycle();
    end
    flush = 1'b0;
    if (capture) begin
      held_res = exp;
      held_tag = tag;
    end
  endtask

  logic [3:0] rand_ops [7] = '{OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  initial begin
    #2_000_000;
    $display("FAIL time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, gap, run, nrsp, overlap;
    logic [31:0] r_res [2];
    logic [4:0]  r_tag [2];
    int          r_cyc [2];

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_alu_op", 32'(alu_op), 32'(OP_ADD));
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    next_cycle();

    // Always-ready ALU: ready is stale in ISSUE and must be ignored.
    stub_always = 1'b1;
    do_txn(OP_MUL, 32'd10, 32'd5, 5'd3, 0, 0, 32'd50);
    do_txn(OP_DIV, 32'd7, 32'd0, 5'd4, 0, 0, 32'hFFFF_FFFF);
    do_txn(OP_REMU, 32'd7, 32'd0, 5'd5, 0, 0, 32'd7);

    // Back-to-back with req_valid held.
    req_valid = 1'b1;
    req_op    = OP_DIV;
    req_a     = 32'hFFFF_FFEC;
    req_b     = 32'd3;
    req_tag   = 5'd1;
    acc = 0; gap = -1; run = 0; nrsp = 0; overlap = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (req_ready && req_valid) acc++;
      if (req_ready && busy) overlap++;
      if (alu_op == OP_ADD) run++;
      else begin
        if (alu_op == OP_REM && gap < 0) gap = run;
        run = 0;
      end
      if (rsp_valid && nrsp < 2) begin
        r_res[nrsp] = rsp_result;
        r_tag[nrsp] = rsp_tag;
        r_cyc[nrsp] = c;
        nrsp++;
      end
      next_cycle();
      if (acc == 1) begin
        req_op  = OP_REM;
        req_tag = 5'd2;
      end else if (acc >= 2) begin
        req_valid = 1'b0;
      end
    end
    check("b2b_nrsp", 32'(nrsp), 32'd2);
    check("b2b_accepts", 32'(acc), 32'd2);
    check("b2b_overlap", 32'(overlap), 32'd0);
    check("b2b_gap_ge2", 32'(gap >= 2), 32'd1);
    if (nrsp == 2) begin
      check("b2b_res0", r_res[0], 32'hFFFF_FFFA);
      check("b2b_tag0", 32'(r_tag[0]), 32'd1);
      check("b2b_cyc0", 32'(r_cyc[0]), 32'd3);
      check("b2b_res1", r_res[1], 32'hFFFF_FFFE);
      check("b2b_tag1", 32'(r_tag[1]), 32'd2);
      check("b2b_cyc1", 32'(r_cyc[1]), 32'd7);
      held_res = r_res[1];
      held_tag = r_tag[1];
    end
    stub_always = 1'b0;

    // Flush two cycles after accept, then a clean DIVU.
    do_txn(OP_DIV, 32'd20, 32'd3, 5'd6, 3, 2, 32'd6);
    do_txn(OP_DIVU, 32'd100, 32'd10, 5'd7, 1, 0, 32'd10);

    // Watchdog: ready never arrives.
    stub_stuck = 1'b1;
    req_valid  = 1'b1;
    req_op     = OP_DIVU;
    req_a      = 32'd9;
    req_b      = 32'd2;
    req_tag    = 5'd9;
    next_cycle();
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("wd_timeout_err", 32'(timeout_err), 32'(c == 10));
      check("wd_rsp_valid", 32'(rsp_valid), 32'd0);
      check("wd_busy", 32'(busy), 32'(c <= 10));
      check("wd_req_ready", 32'(req_ready), 32'(c >= 11));
      check("wd_alu_op", 32'(alu_op), 32'((c <= 10) ? OP_DIVU : OP_ADD));
      check("wd_rsp_result", rsp_result, held_res);
      next_cycle();
    end

    // Reset while waiting on a DIV.
    req_valid = 1'b1;
    req_op    = OP_DIV;
    req_a     = 32'd50;
    req_b     = 32'd7;
    req_tag   = 5'd11;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mrst_alu_op", 32'(alu_op), 32'(OP_ADD));
    check("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_req_ready", 32'(req_ready), 32'd1);
    check("mrst_rsp_result", rsp_result, 32'd0);
    next_cycle();
    stub_stuck = 1'b0;
    held_res   = '0;
    held_tag   = '0;

    // Randomized transactions.
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  tag;
      int          lat, f;
      op  = rand_ops[$urandom_range(0, 6)];
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      tag = 5'($urandom);
      lat = $urandom_range(0, 6);
      f   = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, lat + 4);
      do_txn(op, a, b, tag, lat, f, golden(op, a, b));
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
